// File: rtl/moving_average_filter.sv
// N-tap boxcar averager: circular sample buffer plus running-sum accumulator,
// two-stage pipeline (accumulate, then round/shift) with flush and primed flag.
module moving_average_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_TAPS  = 2,
  parameter int SIGNED     = 0,
  parameter int ROUND      = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_ce,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            i_clear,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            o_ce,
  output logic                            o_primed,
  output logic                            o_sum_ce,
  output logic [DATA_WIDTH+LOG2_TAPS-1:0] o_sum
);

  localparam int TAPS = 1 << LOG2_TAPS;
  localparam int AW   = DATA_WIDTH + LOG2_TAPS;
  localparam logic [LOG2_TAPS:0] TAPS_CNT  = (LOG2_TAPS + 1)'(TAPS);
  localparam logic [AW:0]        ROUND_ADD = (ROUND != 0) ? ((AW + 1)'(1) << (LOG2_TAPS - 1)) : '0;

  logic [DATA_WIDTH-1:0] sample_reg [TAPS];
  logic [LOG2_TAPS-1:0]  wr_ptr_reg;
  logic [LOG2_TAPS:0]    fill_reg;
  logic [LOG2_TAPS:0]    fill_next;
  logic [AW-1:0]         acc_reg;
  logic [AW-1:0]         acc_next;
  logic                  sum_ce_reg;
  logic                  out_ce_reg;
  logic                  primed_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic [DATA_WIDTH-1:0] data_out_next;
  logic [DATA_WIDTH-1:0] oldest;
  logic [AW:0]           rounded;
  logic                  acc_guard;
  logic [TAPS-1:0]       tap_we;
  logic                  unused_round_bits;

  function automatic logic [AW-1:0] ext(input logic [DATA_WIDTH-1:0] d);
    if (SIGNED != 0) begin
      return {{LOG2_TAPS{d[DATA_WIDTH-1]}}, d};
    end
    return {{LOG2_TAPS{1'b0}}, d};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap_we
      assign tap_we[gi] = i_ce && (wr_ptr_reg == LOG2_TAPS'(gi));
    end
  endgenerate

  assign oldest    = sample_reg[wr_ptr_reg];
  assign acc_next  = acc_reg + ext(data_in) - ext(oldest);
  assign fill_next = (fill_reg == TAPS_CNT) ? fill_reg : fill_reg + 1'b1;

  // Guard bit keeps the rounding add from wrapping; it carries the sign when signed.
  assign acc_guard = (SIGNED != 0) ? acc_reg[AW-1] : 1'b0;
  assign rounded   = {acc_guard, acc_reg} + ROUND_ADD;
  // Arithmetic and logical shifts agree on every bit kept after truncation.
  assign data_out_next     = rounded[LOG2_TAPS +: DATA_WIDTH];
  assign unused_round_bits = ^{rounded[AW], rounded[LOG2_TAPS-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      fill_reg     <= '0;
      acc_reg      <= '0;
      sum_ce_reg   <= 1'b0;
      out_ce_reg   <= 1'b0;
      primed_reg   <= 1'b0;
      data_out_reg <= '0;
    end else if (i_clear) begin
      // Flush drops any sample in flight but keeps the last delivered output.
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      acc_reg    <= '0;
      sum_ce_reg <= 1'b0;
      out_ce_reg <= 1'b0;
      primed_reg <= 1'b0;
    end else begin
      sum_ce_reg <= i_ce;
      if (i_ce) begin
        acc_reg    <= acc_next;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        fill_reg   <= fill_next;
      end
      out_ce_reg <= sum_ce_reg;
      if (sum_ce_reg) begin
        data_out_reg <= data_out_next;
        primed_reg   <= (fill_reg == TAPS_CNT);
      end
    end

    for (int i = 0; i < TAPS; i++) begin
      if (reset || i_clear) begin
        sample_reg[i] <= '0;
      end else if (tap_we[i]) begin
        sample_reg[i] <= data_in;
      end
    end
  end

  assign data_out = data_out_reg;
  assign o_ce     = out_ce_reg;
  assign o_primed = primed_reg;
  assign o_sum_ce = sum_ce_reg;
  assign o_sum    = acc_reg;

endmodule

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter: three configurations share one
// stimulus stream (unsigned/truncate, unsigned/round, signed/truncate).
module tb_moving_average_filter;

  logic       clk;
  logic       reset;
  logic       i_ce;
  logic [7:0] data_in;
  logic       i_clear;

  logic [7:0] do0, do1, do2;
  logic       oce0, oce1, oce2;
  logic       pr0, pr1, pr2;
  logic       sce0, sce1, sce2;
  logic [9:0] sum0, sum1, sum2;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [7:0] wrap_in  [5] = '{8'd4, 8'd8, 8'd12, 8'd16, 8'd20};
  logic [7:0] wrap_out [5] = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd14};
  logic [7:0] sgn_in   [5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
  logic [9:0] sgn_sum  [5] = '{10'h3FF, 10'h3FE, 10'h3FD, 10'h3FC, 10'h07C};
  logic [7:0] sgn_out  [5] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F};
  logic       clr_ce   [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [7:0] clr_out  [8] = '{8'd0, 8'd0, 8'd2, 8'd4, 8'd4, 8'd4, 8'd1, 8'd1};

  moving_average_filter #(.DATA_WIDTH(8), .LOG2_TAPS(2), .SIGNED(0), .ROUND(0)) u0 (
    .clk(clk), .reset(reset), .i_ce(i_ce), .data_in(data_in), .i_clear(i_clear),
    .data_out(do0), .o_ce(oce0), .o_primed(pr0), .o_sum_ce(sce0), .o_sum(sum0)
  );
  moving_average_filter #(.DATA_WIDTH(8), .LOG2_TAPS(2), .SIGNED(0), .ROUND(1)) u1 (
    .clk(clk), .reset(reset), .i_ce(i_ce), .data_in(data_in), .i_clear(i_clear),
    .data_out(do1), .o_ce(oce1), .o_primed(pr1), .o_sum_ce(sce1), .o_sum(sum1)
  );
  moving_average_filter #(.DATA_WIDTH(8), .LOG2_TAPS(2), .SIGNED(1), .ROUND(0)) u2 (
    .clk(clk), .reset(reset), .i_ce(i_ce), .data_in(data_in), .i_clear(i_clear),
    .data_out(do2), .o_ce(oce2), .o_primed(pr2), .o_sum_ce(sce2), .o_sum(sum2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic ce, input logic [7:0] d, input logic clr, input logic rst);
    @(negedge clk);
    i_ce    = ce;
    data_in = d;
    i_clear = clr;
    reset   = rst;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; i_ce = 1'b0; data_in = '0; i_clear = 1'b0;

    // Reset state
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 0);
    chk("rst_do0", 32'(do0), 0);   chk("rst_do1", 32'(do1), 0);  chk("rst_do2", 32'(do2), 0);
    chk("rst_oce0", 32'(oce0), 0); chk("rst_sce0", 32'(sce0), 0); chk("rst_pr0", 32'(pr0), 0);
    chk("rst_sum0", 32'(sum0), 0); chk("rst_sum2", 32'(sum2), 0);

    // Fill and wrap, back-to-back
    for (int k = 0; k < 8; k++) begin
      tick(k < 5, (k < 5) ? wrap_in[k] : 8'd0, 0, 0);
      if (k == 1) begin
        chk("wrap_sce", 32'(sce0), 1);
        chk("wrap_sum", 32'(sum0), 4);
        chk("wrap_oce_early", 32'(oce0), 0);
      end
      if (k >= 2 && k < 7) begin
        chk($sformatf("wrap_do0_%0d", k - 2), 32'(do0), 32'(wrap_out[k-2]));
        chk($sformatf("wrap_do1_%0d", k - 2), 32'(do1), 32'(wrap_out[k-2]));
        chk($sformatf("wrap_do2_%0d", k - 2), 32'(do2), 32'(wrap_out[k-2]));
        chk($sformatf("wrap_oce_%0d", k - 2), 32'(oce0), 1);
        chk($sformatf("wrap_pr_%0d", k - 2), 32'(pr0), 32'(k >= 5));
      end
      if (k == 7) begin
        chk("wrap_oce_end", 32'(oce0), 0);
        chk("wrap_do_hold", 32'(do0), 14);
        chk("wrap_pr_hold", 32'(pr0), 1);
      end
    end

    // Rounding on a single sample
    tick(0, 0, 0, 1);
    tick(1, 8'd2, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("rnd_trunc", 32'(do0), 0);
    chk("rnd_round", 32'(do1), 1);
    chk("rnd_oce", 32'(oce1), 1);

    // All-ones: unsigned 255 vs signed -1, then 0x7F
    tick(0, 0, 0, 1);
    for (int k = 0; k < 7; k++) begin
      tick(k < 5, (k < 5) ? sgn_in[k] : 8'd0, 0, 0);
      if (k >= 1 && k < 6) chk($sformatf("sgn_sum_%0d", k - 1), 32'(sum2), 32'(sgn_sum[k-1]));
      if (k >= 2) chk($sformatf("sgn_do_%0d", k - 2), 32'(do2), 32'(sgn_out[k-2]));
      if (k == 2) begin
        chk("max_trunc_1", 32'(do0), 63);
        chk("max_round_1", 32'(do1), 64);
      end
      if (k == 4) chk("sgn_pr_3", 32'(pr2), 0);
      if (k == 5) begin
        chk("max_trunc_4", 32'(do0), 255);
        chk("max_round_4", 32'(do1), 255);
        chk("max_pr_4", 32'(pr0), 1);
      end
      if (k == 6) begin
        chk("max_trunc_5", 32'(do0), 223);
        chk("max_round_5", 32'(do1), 223);
        chk("sgn_pr_5", 32'(pr2), 1);
      end
    end

    // Clear colliding with a strobe: 8, 8, gap, clear+100, 4
    tick(0, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      case (k)
        0, 1:    tick(1, 8'd8, 0, 0);
        3:       tick(1, 8'd100, 1, 0);
        4:       tick(1, 8'd4, 0, 0);
        default: tick(0, 0, 0, 0);
      endcase
      chk($sformatf("clr_oce_%0d", k), 32'(oce0), 32'(clr_ce[k]));
      chk($sformatf("clr_do_%0d", k), 32'(do0), 32'(clr_out[k]));
      chk($sformatf("clr_pr_%0d", k), 32'(pr0), 0);
      if (k == 4) begin
        chk("clr_sum_zero", 32'(sum0), 0);
        chk("clr_sce_zero", 32'(sce0), 0);
      end
      if (k == 5) chk("clr_sum_4", 32'(sum0), 4);
    end

    // Clear while a sample sits in stage 1
    tick(1, 8'd8, 0, 0);
    tick(0, 0, 1, 0);
    chk("clr1_sce", 32'(sce0), 1);
    tick(0, 0, 0, 0);
    chk("clr1_oce", 32'(oce0), 0);
    chk("clr1_sum", 32'(sum0), 0);
    chk("clr1_hold", 32'(do0), 1);
    tick(0, 0, 0, 0);
    chk("clr1_oce_late", 32'(oce0), 0);

    // Reset mid-stream
    tick(1, 8'd12, 0, 0);
    tick(0, 0, 0, 1);
    chk("mid_sce", 32'(sce0), 1);
    tick(0, 0, 0, 0);
    chk("mid_oce", 32'(oce0), 0);
    chk("mid_do", 32'(do0), 0);
    chk("mid_sum", 32'(sum0), 0);
    chk("mid_sce_off", 32'(sce0), 0);
    chk("mid_pr", 32'(pr0), 0);
    tick(0, 0, 0, 0);
    chk("mid_oce_late", 32'(oce0), 0);
    tick(1, 8'd40, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("mid_next_do", 32'(do0), 10);
    chk("mid_next_oce", 32'(oce0), 1);

    // Gapped strobes: one sample every other cycle
    tick(0, 0, 0, 1);
    for (int k = 0; k < 12; k++) begin
      tick((k % 2 == 0) && (k < 10), (k < 10) ? wrap_in[k/2] : 8'd0, 0, 0);
      chk($sformatf("gap_oce_%0d", k), 32'(oce0), 32'((k >= 2) && (k % 2 == 0)));
      if (k >= 2 && k % 2 == 0) begin
        chk($sformatf("gap_do_%0d", k / 2 - 1), 32'(do0), 32'(wrap_out[k/2-1]));
        chk($sformatf("gap_pr_%0d", k / 2 - 1), 32'(pr0), 32'(k / 2 - 1 >= 3));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
